// File: rtl/data_mem_unit.sv
// data_mem_unit: word-organised data memory for the MEM stage.
// Lane-0 aligned write data is shifted into place using byte enables.
// Read data is returned combinationally, with the addressed byte or halfword
// shifted down to lane 0. A sticky flag records misaligned accesses.
// A two-cycle-per-word handshaked dump port streams the whole array to the
// debug unit while the pipeline is halted.
`timescale 1ns/1ps

module data_mem_unit #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 32,
    parameter int NB_MEM_CTRL = 6,
    parameter int N_ELEMENTS  = 128,
    localparam int ADDRW      = $clog2(N_ELEMENTS)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_ADDR-1:0]     i_address,
    input  logic [NB_MEM_CTRL-1:0] i_mem_control,
    input  logic [NB_DATA-1:0]     i_data_write,
    output logic [NB_DATA-1:0]     o_data_read,
    output logic                   o_misaligned,
    input  logic                   i_clear_flag,
    input  logic                   i_dump_start,
    input  logic                   i_dump_ready,
    output logic                   o_dump_valid,
    output logic [NB_DATA-1:0]     o_dump_data,
    output logic [ADDRW-1:0]       o_dump_addr,
    output logic                   o_busy,
    output logic                   o_dump_done
);

    localparam int NB_BYTES = NB_DATA / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NB_DATA-1:0]   r_mem [N_ELEMENTS];
    logic                 r_misaligned;
    logic [ADDRW-1:0]     r_dump_addr;
    logic [NB_DATA-1:0]   r_dump_data;

    logic [ADDRW-1:0]     w_idx;
    logic [1:0]           w_off;
    logic                 w_rd;
    logic                 w_wr;
    logic [2:0]           w_size;
    logic                 w_aligned;
    logic [NB_BYTES-1:0]  w_byte_en;
    logic [NB_DATA-1:0]   w_wdata;
    logic                 w_idle;
    logic                 w_wr_en;
    logic                 w_set_flag;
    logic                 w_last_word;
    logic                 w_unused;

    // Higher address bits alias onto the array; bit 0 of the control word
    // selects sign extension, which happens downstream in the controller.
    assign w_unused = ^{i_address[NB_ADDR-1:ADDRW+2], i_mem_control[0]};

    assign w_idx  = i_address[ADDRW+1:2];
    assign w_off  = i_address[1:0];
    assign w_rd   = i_mem_control[5];
    assign w_wr   = i_mem_control[4];
    assign w_size = i_mem_control[3:1];
    assign w_idle = (r_state == ST_IDLE);

    // Alignment check and byte-enable generation from the one-hot size field.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        w_aligned = 1'b0;
        w_byte_en = '0;
        case (w_size)
            3'b001: begin
                w_aligned = 1'b1;
                w_byte_en = 4'b0001 << w_off;
            end
            3'b010: begin
                w_aligned = ~w_off[0];
                w_byte_en = 4'b0011 << w_off;
            end
            3'b100: begin
                w_aligned = (w_off == 2'b00);
                w_byte_en = 4'b1111;
            end
            default: begin
                w_aligned = 1'b0;
                w_byte_en = '0;
            end
        endcase
    end

    // Writes are dropped while a dump is in progress, so they cannot flag either.
    assign w_wr_en    = w_wr & w_aligned & w_idle;
    assign w_set_flag = ~w_aligned & (w_rd | (w_wr & w_idle));
    assign w_wdata    = i_data_write << {w_off, 3'b000};

    // Combinational read; upper lanes are left for the controller to truncate.
    assign o_data_read = (w_rd && w_aligned) ? (r_mem[w_idx] >> {w_off, 3'b000}) : '0;

    // Memory array: byte-enabled write, cleared by reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        // NOTE: the array is reset because its zeroed contents are architecturally visible on the read and dump ports; this forces flops instead of a RAM macro.
        if (!i_reset) begin
            for (int i = 0; i < N_ELEMENTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < NB_BYTES; b++) begin
                if (w_byte_en[b]) begin
                    // NOTE: non-blocking assignment, so a same-cycle read still sees the pre-edge word.
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Sticky misalignment flag; a new misaligned access wins over a clear.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_misaligned <= 1'b0;
        end else if (w_set_flag) begin
            r_misaligned <= 1'b1;
        end else if (i_clear_flag) begin
            r_misaligned <= 1'b0;
        end
    end

    // Dump FSM state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_last_word = (r_dump_addr == ADDRW'(N_ELEMENTS - 1));

    // Dump FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_dump_start) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_SEND;
            ST_SEND: begin
                if (i_dump_ready) begin
                    w_next_state = w_last_word ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Dump address/data registers: latch in LOAD, hold through SEND stalls.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_dump_addr <= '0;
            r_dump_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_dump_addr <= '0;
                ST_LOAD: r_dump_data <= r_mem[r_dump_addr];
                ST_SEND: begin
                    if (i_dump_ready && !w_last_word) begin
                        r_dump_addr <= r_dump_addr + ADDRW'(1);
                    end
                end
                ST_DONE: r_dump_addr <= '0;
                default: r_dump_addr <= '0;
            endcase
        end
    end

    assign o_misaligned = r_misaligned;
    assign o_dump_valid = (r_state == ST_SEND);
    assign o_dump_data  = r_dump_data;
    assign o_dump_addr  = r_dump_addr;
    assign o_busy       = ~w_idle;
    assign o_dump_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_data_mem_unit.sv
// Testbench for data_mem_unit: directed and randomized accesses checked
// against a byte-addressed reference memory, plus dump-port scenarios.
`timescale 1ns/1ps

module tb_data_mem_unit;

    localparam int NB_DATA     = 32;
    localparam int NB_ADDR     = 32;
    localparam int NB_MEM_CTRL = 6;
    localparam int N_ELEMENTS  = 128;
    localparam int ADDRW       = 7;

    logic                   i_clock = 1'b0;
    logic                   i_reset = 1'b0;
    logic [NB_ADDR-1:0]     i_address = '0;
    logic [NB_MEM_CTRL-1:0] i_mem_control = '0;
    logic [NB_DATA-1:0]     i_data_write = '0;
    logic [NB_DATA-1:0]     o_data_read;
    logic                   o_misaligned;
    logic                   i_clear_flag = 1'b0;
    logic                   i_dump_start = 1'b0;
    logic                   i_dump_ready = 1'b0;
    logic                   o_dump_valid;
    logic [NB_DATA-1:0]     o_dump_data;
    logic [ADDRW-1:0]       o_dump_addr;
    logic                   o_busy;
    logic                   o_dump_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: a flat byte-addressed memory and a flag bit.
    byte unsigned mem_b [N_ELEMENTS*4];
    bit           m_flag;

    data_mem_unit #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR),
        .NB_MEM_CTRL(NB_MEM_CTRL), .N_ELEMENTS(N_ELEMENTS)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_address(i_address),
        .i_mem_control(i_mem_control), .i_data_write(i_data_write),
        .o_data_read(o_data_read), .o_misaligned(o_misaligned),
        .i_clear_flag(i_clear_flag), .i_dump_start(i_dump_start),
        .i_dump_ready(i_dump_ready), .o_dump_valid(o_dump_valid),
        .o_dump_data(o_dump_data), .o_dump_addr(o_dump_addr),
        .o_busy(o_busy), .o_dump_done(o_dump_done)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] s, input logic [31:0] a);
        int n = nbytes(s);
        if (n == 0) return 1'b0;
        return (a % n) == 0;
    endfunction

    function automatic int base_of(input logic [31:0] a);
        return int'((a / 4) % N_ELEMENTS) * 4;
    endfunction

    function automatic logic [31:0] m_word(input int idx);
        return {mem_b[idx*4+3], mem_b[idx*4+2], mem_b[idx*4+1], mem_b[idx*4]};
    endfunction

    function automatic logic [31:0] m_read(input bit rd, input logic [2:0] s, input logic [31:0] a);
        if (!rd || !legal(s, a)) return 32'h0;
        return m_word(base_of(a) / 4) >> (8 * int'(a % 4));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_ELEMENTS*4; i++) mem_b[i] = 8'h00;
        m_flag = 1'b0;
    endtask

    // One pipeline access: drive, sample the combinational read, clock it in,
    // update the model, then sample the flag.
    task automatic access(input bit rd, input bit wr, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] d, input bit clr,
                          output logic [31:0] rd_obs, output logic flag_obs);
        i_address     = a;
        i_mem_control = {rd, wr, s, 1'b0};
        i_data_write  = d;
        i_clear_flag  = clr;
        #3;
        rd_obs = o_data_read;
        @(posedge i_clock);
        #1;
        if ((rd || wr) && !legal(s, a)) m_flag = 1'b1;
        else if (clr)                   m_flag = 1'b0;
        if (wr && legal(s, a)) begin
            for (int i = 0; i < nbytes(s); i++) begin
                mem_b[base_of(a) + int'(a % 4) + i] = d[8*i +: 8];
            end
        end
        i_mem_control = '0;
        i_clear_flag  = 1'b0;
        flag_obs = o_misaligned;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_address = 32'h10;
        i_mem_control = 6'b100100;
        #12;
        checks++;
        if (o_data_read !== 32'h0) begin failures++; $display("FAIL reset_read got=%h exp=0", o_data_read); end
        checks++;
        if ({o_misaligned, o_dump_valid, o_busy, o_dump_done} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {o_misaligned, o_dump_valid, o_busy, o_dump_done});
        end
        checks++;
        if (o_dump_data !== 32'h0 || o_dump_addr !== 7'h0) begin
            failures++; $display("FAIL reset_dump_regs data=%h addr=%h exp=0/0", o_dump_data, o_dump_addr);
        end
        i_mem_control = '0;
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        model_reset();
    endtask

    task automatic test_word();
        logic [31:0] r;
        logic f;
        access(1, 1, 3'b100, 32'h10, 32'hDEADBEEF, 0, r, f);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL word_same_cycle got=%h exp=0", r); end
        access(1, 0, 3'b100, 32'h10, 32'h0, 0, r, f);
        checks++;
        if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL word_read got=%h exp=deadbeef", r); end
    endtask

    task automatic test_bytes();
        logic [31:0] r;
        logic f;
        access(0, 1, 3'b001, 32'h20, 32'h11, 0, r, f);
        access(0, 1, 3'b001, 32'h21, 32'h22, 0, r, f);
        access(0, 1, 3'b001, 32'h22, 32'h33, 0, r, f);
        access(0, 1, 3'b001, 32'h23, 32'h44, 0, r, f);
        access(1, 0, 3'b100, 32'h20, 32'h0, 0, r, f);
        checks++;
        if (r !== 32'h44332211) begin failures++; $display("FAIL byte_word_read got=%h exp=44332211", r); end
        access(1, 0, 3'b001, 32'h22, 32'h0, 0, r, f);
        checks++;
        if (r[7:0] !== 8'h33) begin failures++; $display("FAIL byte_read got=%h exp=33", r[7:0]); end
        checks++;
        if (r !== 32'h00004433) begin failures++; $display("FAIL byte_read_upper got=%h exp=00004433", r); end
    endtask

    task automatic test_half();
        logic [31:0] r;
        logic f;
        access(0, 1, 3'b100, 32'h30, 32'h12345678, 0, r, f);
        access(0, 1, 3'b010, 32'h32, 32'h0000ABCD, 0, r, f);
        access(1, 0, 3'b100, 32'h30, 32'h0, 0, r, f);
        checks++;
        if (r !== 32'hABCD5678) begin failures++; $display("FAIL half_word_read got=%h exp=abcd5678", r); end
        access(1, 0, 3'b010, 32'h32, 32'h0, 0, r, f);
        checks++;
        if (r[15:0] !== 16'hABCD) begin failures++; $display("FAIL half_read got=%h exp=abcd", r[15:0]); end
    endtask

    task automatic test_misaligned();
        logic [31:0] r;
        logic f;
        access(0, 1, 3'b100, 32'h41, 32'hFFFFFFFF, 0, r, f);
        checks++;
        if (f !== 1'b1) begin failures++; $display("FAIL mis_set got=%b exp=1", f); end
        access(1, 0, 3'b100, 32'h40, 32'h0, 0, r, f);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL mis_no_write got=%h exp=0", r); end
        access(1, 0, 3'b100, 32'h41, 32'h0, 0, r, f);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL mis_read got=%h exp=0", r); end
        access(0, 0, 3'b000, 32'h0, 32'h0, 1, r, f);
        checks++;
        if (f !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", f); end
        access(0, 1, 3'b010, 32'h43, 32'h1234, 1, r, f);
        checks++;
        if (f !== 1'b1) begin failures++; $display("FAIL mis_set_over_clear got=%b exp=1", f); end
        access(0, 0, 3'b000, 32'h0, 32'h0, 1, r, f);
        checks++;
        if (f !== 1'b0) begin failures++; $display("FAIL mis_clear2 got=%b exp=0", f); end
    endtask

    task automatic test_random();
        logic [31:0] r, a, d, exp;
        logic f;
        logic [2:0] s;
        bit rd, wr, clr;
        int pick;
        for (int n = 0; n < 300; n++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 9));
            s    = (pick < 3) ? 3'b001 : (pick < 6) ? 3'b010 : (pick < 9) ? 3'b100 : 3'($urandom_range(0, 7));
            a    = 32'($urandom_range(0, 2047));
            d    = $urandom;
            clr  = ($urandom_range(0, 9) == 0);
            exp  = m_read(rd, s, a);
            access(rd, wr, s, a, d, clr, r, f);
            checks++;
            if (r !== exp) begin failures++; $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", n, a, r, exp); end
            checks++;
            if (f !== m_flag) begin failures++; $display("FAIL rand_flag[%0d] got=%b exp=%b", n, f, m_flag); end
        end
    endtask

    // Runs one dump; optional random ready, pipeline traffic while busy,
    // and an asynchronous reset once word abort_at is presented.
    task automatic run_dump(input bit rand_ready, input bit traffic, input int abort_at,
                            input bit zero_data, output int n, output int done_cnt, output int done_cyc);
        bit stalled = 1'b0;
        bit finished = 1'b0;
        logic [31:0] sd = '0;
        logic [6:0]  sa = '0;
        logic [31:0] exp;
        n = 0; done_cnt = 0; done_cyc = -1;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            i_dump_start  = (cyc == 0) || (cyc == 30);
            i_dump_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_mem_control = '0;
            i_clear_flag  = 1'b0;
            if (traffic && cyc == 10) begin
                i_address = 32'h40; i_data_write = 32'hCAFEF00D; i_mem_control = 6'b010100;
            end
            if (traffic && cyc == 12) begin
                i_address = 32'h41; i_data_write = 32'hFFFFFFFF; i_mem_control = 6'b010100;
            end
            if (traffic && cyc == 20) begin
                i_address = 32'h44; i_mem_control = 6'b100100;
            end
            #3;
            if (traffic && cyc == 20) begin
                checks++;
                if (o_data_read !== 32'd51) begin failures++; $display("FAIL dump_busy_read got=%h exp=%h", o_data_read, 32'd51); end
            end
            if (cyc == 5) begin
                checks++;
                if (o_busy !== 1'b1) begin failures++; $display("FAIL dump_busy got=%b exp=1", o_busy); end
            end
            if (o_dump_done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end
            if (o_dump_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (o_dump_data !== sd || o_dump_addr !== sa) begin
                        failures++; $display("FAIL dump_stall data=%h addr=%0d exp=%h/%0d", o_dump_data, o_dump_addr, sd, sa);
                    end
                end
                if (abort_at >= 0 && n == abort_at) begin
                    i_reset = 1'b0;
                    #1;
                    checks++;
                    if (o_busy !== 1'b0 || o_dump_valid !== 1'b0) begin
                        failures++; $display("FAIL reset_mid_dump busy=%b valid=%b exp=0/0", o_busy, o_dump_valid);
                    end
                    model_reset();
                    finished = 1'b1;
                end else if (i_dump_ready) begin
                    exp = zero_data ? 32'h0 : 32'(n * 3);
                    checks++;
                    if (o_dump_addr !== 7'(n) || o_dump_data !== exp) begin
                        failures++; $display("FAIL dump_word[%0d] addr=%0d data=%h exp=%0d/%h", n, o_dump_addr, o_dump_data, n, exp);
                    end
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sd = o_dump_data;
                    sa = o_dump_addr;
                end
            end else begin
                stalled = 1'b0;
            end
            if (!finished) begin
                @(posedge i_clock);
                #1;
                if (done_cnt > 0 && cyc >= done_cyc + 2) finished = 1'b1;
            end
        end
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        i_mem_control = '0;
        if (!finished) begin
            failures++; $display("FAIL dump_timeout words=%0d done=%0d", n, done_cnt);
        end
    endtask

    task automatic test_dump();
        logic [31:0] r;
        logic f;
        int n, done_cnt, done_cyc;
        for (int k = 0; k < N_ELEMENTS; k++) begin
            access(0, 1, 3'b100, 32'(k * 4), 32'(k * 3), (k == 0), r, f);
        end
        run_dump(1, 1, -1, 0, n, done_cnt, done_cyc);
        checks++;
        if (n !== N_ELEMENTS) begin failures++; $display("FAIL dump_count got=%0d exp=%0d", n, N_ELEMENTS); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL dump_done_pulses got=%0d exp=1", done_cnt); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL dump_idle_after got=%b exp=0", o_busy); end
        checks++;
        if (o_misaligned !== 1'b0) begin failures++; $display("FAIL dump_no_flag got=%b exp=0", o_misaligned); end
        access(1, 0, 3'b100, 32'h40, 32'h0, 0, r, f);
        checks++;
        if (r !== 32'd48 || r !== m_read(1, 3'b100, 32'h40)) begin
            failures++; $display("FAIL dump_write_dropped got=%h exp=%h", r, 32'd48);
        end
    endtask

    task automatic test_reset_mid_dump();
        int n, done_cnt, done_cyc;
        run_dump(0, 0, 50, 0, n, done_cnt, done_cyc);
        checks++;
        if (n !== 50) begin failures++; $display("FAIL reset_mid_words got=%0d exp=50", n); end
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        run_dump(0, 0, -1, 1, n, done_cnt, done_cyc);
        checks++;
        if (n !== N_ELEMENTS) begin failures++; $display("FAIL redump_count got=%0d exp=%0d", n, N_ELEMENTS); end
        checks++;
        if (done_cyc !== 257) begin failures++; $display("FAIL redump_latency got=%0d exp=257", done_cyc); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL redump_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_half();
        test_misaligned();
        test_random();
        test_dump();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
